// File: rtl/uart_rx_reader.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// single-entry valid/ready output register with framing-error and overrun pulses.
module uart_rx_reader #(
   parameter int clk_mhz  = 50,
   parameter int boadrate = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       valid,
   output logic [7:0] data,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic [2:0] state_dbg
);

   localparam int scale = clk_mhz * 1000 * 1000 / boadrate;
   localparam int half  = scale / 2;
   localparam logic [31:0] scale_m1 = 32'(scale - 1);
   localparam logic [31:0] half_m1  = 32'(half - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t      state;
   logic        rx_m;
   logic        rx_s;
   logic [31:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  sh;
   logic        tick;

   assign tick      = (cnt == '0);
   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // Handshake: a byte in data is transferred on any cycle where valid & ready
   // are both high; valid then drops unless a new byte loads in that same cycle.
   // A finished byte arriving while the register is full and not being taken
   // is dropped and flagged with a one-cycle overrun pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         sh        <= '0;
         valid     <= 1'b0;
         data      <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (valid && ready)
            valid <= 1'b0;
         if (!tick)
            cnt <= cnt - 32'd1;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  cnt   <= half_m1;
                  state <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (!rx_s) begin
                     cnt     <= scale_m1;
                     bit_idx <= '0;
                     state   <= DATA;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  sh  <= {rx_s, sh[7:1]};
                  cnt <= scale_m1;
                  if (bit_idx == 3'd7)
                     state <= STOP;
                  else
                     bit_idx <= bit_idx + 3'd1;
               end
            end
            STOP: begin
               if (tick) begin
                  if (rx_s) begin
                     if (!valid || ready) begin
                        data  <= sh;
                        valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end
               end
            end
            // Hold off until the line returns high so a break cannot retrigger.
            WAIT_HIGH: begin
               if (rx_s)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_reader.sv
// Directed bench for uart_rx_reader at 10 clocks per bit: single byte, streaming,
// glitch, framing error, overrun, simultaneous load, reset abort and a byte sequence.
module tb_uart_rx_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       ready;
   logic       valid;
   logic [7:0] data;
   logic       frame_err;
   logic       overrun;
   logic [2:0] state_dbg;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];
   int         cyc = 0;
   int         start_cyc = 0;
   int         rise_cyc = -1;
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   int         fe0, ov0;
   logic       both_seen = 1'b0;
   logic       prev_valid = 1'b0;

   uart_rx_reader #(.clk_mhz(1), .boadrate(100000)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .valid     (valid),
      .data      (data),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // scoreboard: every accepted byte must match the head of exp_q
   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_seen = 1'b1;
      if (valid && !prev_valid) rise_cyc = cyc;
      prev_valid = valid;
      if (valid && ready) begin
         if (exp_q.size() == 0)
            check("extra_byte", 32'(exp_q.size()), 32'd1);
         else
            check("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
   end

   // driver tasks
   task automatic hold_bit(input logic lvl);
      rx = lvl;
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int nstop);
      @(posedge clk);
      #1;
      start_cyc = cyc;
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(d[i]);
      for (int i = 0; i < nstop; i++) hold_bit(stop_lvl);
   endtask

   task automatic pulse_ready();
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      miscompares++;
      vectors++;
      $display("FAIL watchdog: run did not complete, time %0t", $time);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      rst = 1'b1;
      rx = 1'b1;
      ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_data", {24'd0, data}, 32'd0);
      check("reset_state", {29'd0, state_dbg}, 32'd0);
      check("reset_pulses", {30'd0, frame_err, overrun}, 32'd0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // single byte, ready low; valid rises 98 cycles after the line start edge
      send_frame(8'hA5, 1'b1, 1);
      check("single_valid", {31'd0, valid}, 32'd1);
      check("single_data", {24'd0, data}, 32'hA5);
      check("single_latency", 32'(rise_cyc - start_cyc), 32'd98);
      exp_q.push_back(8'hA5);
      pulse_ready();
      check("single_clear", {31'd0, valid}, 32'd0);

      // back-to-back with ready held high
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      ready = 1'b1;
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      send_frame(8'h3C, 1'b1, 2);
      send_frame(8'hFF, 1'b1, 2);
      send_frame(8'h00, 1'b1, 2);
      repeat (5) @(posedge clk);
      #1;
      check("b2b_drained", 32'(exp_q.size()), 32'd0);
      check("b2b_no_fe", 32'(fe_cnt - fe0), 32'd0);
      check("b2b_no_ov", 32'(ov_cnt - ov0), 32'd0);

      // 3-clock glitch on idle line
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("glitch_state", {29'd0, state_dbg}, 32'd0);
      check("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
      check("glitch_valid", {31'd0, valid}, 32'd0);
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, 1);
      repeat (3) @(posedge clk);
      #1;
      check("glitch_next", 32'(exp_q.size()), 32'd0);

      // framing error: stop low plus 30 more low clocks
      fe0 = fe_cnt;
      send_frame(8'h81, 1'b0, 4);
      check("fe_wait_high", {29'd0, state_dbg}, 32'd4);
      rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("fe_count", 32'(fe_cnt - fe0), 32'd1);
      check("fe_valid", {31'd0, valid}, 32'd0);
      check("fe_state", {29'd0, state_dbg}, 32'd0);
      exp_q.push_back(8'h42);
      send_frame(8'h42, 1'b1, 1);
      repeat (3) @(posedge clk);
      #1;
      check("fe_next", 32'(exp_q.size()), 32'd0);

      // overrun with ready low
      ready = 1'b0;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(8'h11, 1'b1, 1);
      send_frame(8'h22, 1'b1, 1);
      check("ov_data", {24'd0, data}, 32'h11);
      check("ov_valid", {31'd0, valid}, 32'd1);
      check("ov_count", 32'(ov_cnt - ov0), 32'd1);
      check("ov_no_fe", 32'(fe_cnt - fe0), 32'd0);
      exp_q.push_back(8'h11);
      pulse_ready();
      check("ov_clear", {31'd0, valid}, 32'd0);

      // byte completes in the same cycle the held byte is taken
      ov0 = ov_cnt;
      send_frame(8'h33, 1'b1, 1);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h44);
      fork
         send_frame(8'h44, 1'b1, 1);
         begin
            @(posedge clk);
            repeat (97) @(posedge clk);
            #1;
            ready = 1'b1;
            @(posedge clk);
            #1;
            ready = 1'b0;
         end
      join
      repeat (2) @(posedge clk);
      #1;
      check("simul_data", {24'd0, data}, 32'h44);
      check("simul_valid", {31'd0, valid}, 32'd1);
      check("simul_no_ov", 32'(ov_cnt - ov0), 32'd0);
      pulse_ready();
      check("simul_drained", 32'(exp_q.size()), 32'd0);

      // reset during data bit 4 of 0xC3
      ready = 1'b1;
      fe0 = fe_cnt;
      @(posedge clk);
      #1;
      hold_bit(1'b0);
      hold_bit(1'b1);
      hold_bit(1'b1);
      hold_bit(1'b0);
      hold_bit(1'b0);
      rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      rx = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_state", {29'd0, state_dbg}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      repeat (120) @(posedge clk);
      #1;
      check("rst_no_fe", 32'(fe_cnt - fe0), 32'd0);
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b1, 1);
      repeat (3) @(posedge clk);
      #1;
      check("rst_resend", 32'(exp_q.size()), 32'd0);

      // transmitter-style sequence, 2 stop bits
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h7E);
      exp_q.push_back(8'hFE);
      send_frame(8'h01, 1'b1, 2);
      send_frame(8'h7E, 1'b1, 2);
      send_frame(8'hFE, 1'b1, 2);
      repeat (5) @(posedge clk);
      #1;

      // final report
      check("final_drained", 32'(exp_q.size()), 32'd0);
      check("fe_ov_exclusive", {31'd0, both_seen}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
